pattern_sequencer: RTL and testbench
====================================

# pattern_sequencer

Parametrised N-state LED pattern sequencer for the board front panel, the successor to the two-state key-toggled machine. It debounces the active-low push buttons and steps through NUM_STATES states, forward or backward, manually or on an automatic tick. Each state drives a rotated alternating pattern on LEDR, and two seven-segment digits show the current state and a wrap counter.

## Interface
- NUM_STATES, 2, number of states; legal 2..16; state register width SW = max(1, clog2(NUM_STATES))
- LED_WIDTH, 10, LEDR width; legal 2..10
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a debounced key level changes; legal >= 1
- AUTO_PERIOD, 0, cycles between automatic steps; 0 disables auto stepping
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  synchronous, active-low reset
- KEY  input  2  raw push buttons, active-low, asynchronous to clk; KEY[0] = step, KEY[1] = toggle direction
- LEDR  output  LED_WIDTH  registered pattern for the current state
- HEX0  output  8  active-low seven-segment display of the current state as a hex digit; bit 7 (DP) held at 1
- HEX1  output  8  active-low seven-segment display of the wrap counter (mod 16) as a hex digit; DP held at 1

## Operation
- Each KEY bit passes through a 2-flop synchroniser and then a debouncer. The debounced level starts at 1 (released). It flips only after the synchronised level has differed from it for DEBOUNCE_CYCLES consecutive edges; any agreement in between clears the counter.
- A press event is a registered one-cycle pulse on a debounced 1->0 transition. Releases generate no event.
- Direction register dir: 0 = forward, 1 = backward. A KEY[1] press toggles dir.
- Step event = KEY[0] press OR auto tick.
  - Forward: state+1. From NUM_STATES-1 it wraps to 0 and wrap_cnt increments (4-bit, mod 16).
  - Backward: state-1. From 0 it wraps to NUM_STATES-1 and wrap_cnt decrements (mod 16).
- Auto tick (AUTO_PERIOD > 0 only): a free-running counter counts 0..AUTO_PERIOD-1 and pulses at the terminal count. A manual step restarts the counter at 0.
- Pattern: base = LED_WIDTH bits with every odd-index bit set (10'h2AA for width 10). LEDR = base rotated left by (state mod LED_WIDTH). For width 10: state 0 -> 10'h2AA, 1 -> 10'h155, 2 -> 10'h2AA.
- Seven-segment encoding via the codebase's bcd_decoder with DP off: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90, A=88, b=83, C=C6, d=A1, E=86, F=8E.
- Simultaneous events in one cycle:
  - KEY[1] and KEY[0] presses: the toggle applies first, and the step uses the new direction.
  - Auto tick and KEY[0] press: exactly one step occurs, and the auto counter restarts.

## Timing
- Reset (reset=0 at an edge): state=0, dir=0, wrap_cnt=0, debounced levels=1, synchroniser flops=1, debounce and auto counters=0, press pulses=0.
  - Outputs after that edge: LEDR=base (10'h2AA), HEX0=8'hC0, HEX1=8'hC0.
  - Reset takes effect mid-debounce or mid-auto-period; no pending event survives it.
- All outputs are registered and change only on clk edges.
- Key latency: KEY low first sampled at edge e0 and held low. The debounced level flips at e0+DEBOUNCE_CYCLES+1, the press pulse is high after e0+DEBOUNCE_CYCLES+2, and state/LEDR/HEX update at e0+DEBOUNCE_CYCLES+3.
- A key held low produces exactly one event. A further event requires a debounced release followed by a debounced press.
- Auto step: state changes every AUTO_PERIOD cycles. The first auto step is at edge AUTO_PERIOD after reset release.
- A bounce shorter than DEBOUNCE_CYCLES cycles produces no event.

## Test plan
- Reset: NUM_STATES=4, DEBOUNCE_CYCLES=4, AUTO_PERIOD=0; hold reset=0 for 3 cycles -> LEDR=10'h2AA, HEX0=C0, HEX1=C0.
- Forward wrap: 4 clean KEY[0] presses -> HEX0 sequence F9, A4, B0, C0; LEDR alternates 155/2AA; HEX1=F9 after the 4th press. Each update lands exactly 7 cycles after the first low sample.
- Reverse: 1 KEY[1] press, then 1 KEY[0] press from state 0 -> state 3 (HEX0=B0), wrap_cnt=15 (HEX1=8E).
- Bounce rejection: KEY[0] low for 3 cycles, high 1 cycle, repeated 5 times, then held high -> no state change. Then held low for 20 cycles -> exactly one step.
- Auto mode and collision: AUTO_PERIOD=8 -> steps at edges 8, 16, 24 after reset release. A KEY[0] press landing on the tick cycle -> single step, and the next auto step comes 8 cycles later.
- Mid-operation reset: assert reset=0 while the debounce counter is 2 and state=2 -> outputs return to the reset values, and the pending press produces no step after release.

Source files
------------

// File: rtl/pattern_sequencer_if.sv
// Front-panel bundle for pattern_sequencer.
//   KEY  : raw active-low push buttons (KEY[0] = step, KEY[1] = toggle direction)
//   LEDR : registered LED pattern for the current state
//   HEX0 : active-low seven-segment digit showing the current state
//   HEX1 : active-low seven-segment digit showing the wrap counter
// The slave modport is the sequencer side; the master modport is the board/driver side.
interface pattern_sequencer_if #(
  parameter int unsigned LED_WIDTH = 10
) ();

  logic [1:0]           KEY;
  logic [LED_WIDTH-1:0] LEDR;
  logic [7:0]           HEX0;
  logic [7:0]           HEX1;

  modport master (
    output KEY,
    input  LEDR,
    input  HEX0,
    input  HEX1
  );

  modport slave (
    input  KEY,
    output LEDR,
    output HEX0,
    output HEX1
  );

endinterface

// File: rtl/pattern_sequencer.sv
// N-state LED pattern sequencer for the board front panel.
// Both raw keys are synchronised, debounced and turned into one-cycle press pulses.
// A KEY[1] press toggles the stepping direction; a KEY[0] press (or the optional
// automatic tick) steps the state forward or backward, wrapping at the ends and
// counting wraps in a 4-bit counter. LEDR shows an alternating pattern rotated by
// the state; HEX0/HEX1 show state and wrap count as hex digits.
// Ports:
//   clk   : single clock, all state changes on its rising edge
//   reset : synchronous, active-low reset
//   bus   : front-panel interface (KEY in, LEDR/HEX0/HEX1 out), slave side
module pattern_sequencer #(
  parameter int unsigned NUM_STATES      = 2,
  parameter int unsigned LED_WIDTH       = 10,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned AUTO_PERIOD     = 0
) (
  input logic               clk,
  input logic               reset,
  pattern_sequencer_if.slave bus
);

  localparam int unsigned SW = (NUM_STATES > 2) ? $clog2(NUM_STATES) : 1;
  localparam int unsigned DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  localparam logic [SW-1:0] StLast   = SW'(NUM_STATES - 1);
  localparam logic [DW-1:0] DebLast  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] AutoLast = AW'((AUTO_PERIOD == 0) ? 0 : AUTO_PERIOD - 1);

  // Every odd-index bit set.
  function automatic logic [LED_WIDTH-1:0] base_pattern();
    logic [LED_WIDTH-1:0] p;
    p = '0;
    for (int i = 1; i < int'(LED_WIDTH); i += 2) begin
      p[i] = 1'b1;
    end
    return p;
  endfunction

  localparam logic [LED_WIDTH-1:0] BasePat = base_pattern();

  // Active-low seven-segment code, DP off.
  function automatic logic [7:0] hex_seg(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'h0:    s = 8'hC0;
      4'h1:    s = 8'hF9;
      4'h2:    s = 8'hA4;
      4'h3:    s = 8'hB0;
      4'h4:    s = 8'h99;
      4'h5:    s = 8'h92;
      4'h6:    s = 8'h82;
      4'h7:    s = 8'hF8;
      4'h8:    s = 8'h80;
      4'h9:    s = 8'h90;
      4'hA:    s = 8'h88;
      4'hB:    s = 8'h83;
      4'hC:    s = 8'hC6;
      4'hD:    s = 8'hA1;
      4'hE:    s = 8'h86;
      default: s = 8'h8E;
    endcase
    return s;
  endfunction

  // Key conditioning
  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    deb_q, deb_d;
  logic [1:0]    deb_prev_q;
  logic [1:0]    press_q, press_d;
  logic [DW-1:0] deb_cnt_q [2];
  logic [DW-1:0] deb_cnt_d [2];

  // Sequencer state
  logic [SW-1:0]        state_q, state_d;
  logic                 dir_q, dir_d;
  logic [3:0]           wrap_q, wrap_d;
  logic [AW-1:0]        auto_cnt_q, auto_cnt_d;
  logic                 auto_tick;
  logic                 step;

  // Registered outputs
  logic [LED_WIDTH-1:0] ledr_q, ledr_d;
  logic [7:0]           hex0_q, hex0_d;
  logic [7:0]           hex1_q, hex1_d;
  int unsigned          rot_amt;

  // The debounced level only follows the synchronised level after DEBOUNCE_CYCLES
  // consecutive disagreeing samples; any agreeing sample clears the run.
  always_comb begin
    deb_d = deb_q;
    for (int i = 0; i < 2; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_d[i]     = sync2_q[i];
          deb_cnt_d[i] = '0;
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
        end
      end
    end
    // Falling debounced level = press; releases are ignored.
    press_d = deb_prev_q & ~deb_q;
  end

  always_comb begin
    auto_tick = (AUTO_PERIOD != 0) && (auto_cnt_q == AutoLast);
    // The toggle lands first so a simultaneous step uses the new direction.
    dir_d     = dir_q ^ press_q[1];
    // A manual press and an auto tick in the same cycle merge into one step.
    step      = press_q[0] | auto_tick;
    state_d   = state_q;
    wrap_d    = wrap_q;

    if (step) begin
      if (!dir_d) begin
        if (state_q == StLast) begin
          state_d = '0;
          wrap_d  = wrap_q + 4'd1;
        end else begin
          state_d = state_q + 1'b1;
        end
      end else begin
        if (state_q == '0) begin
          state_d = StLast;
          wrap_d  = wrap_q - 4'd1;
        end else begin
          state_d = state_q - 1'b1;
        end
      end
    end

    auto_cnt_d = '0;
    if (AUTO_PERIOD != 0 && !step) begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  // Outputs are computed from the next state so they move on the same edge as it.
  always_comb begin
    rot_amt = 32'(state_d) % LED_WIDTH;
    // Lower half of the doubled pattern shifted right by (W - r) is a left rotate by r.
    ledr_d  = LED_WIDTH'({BasePat, BasePat} >> (LED_WIDTH - rot_amt));
    hex0_d  = hex_seg(4'(state_d));
    hex1_d  = hex_seg(wrap_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 2'b11;
      sync2_q    <= 2'b11;
      deb_q      <= 2'b11;
      deb_prev_q <= 2'b11;
      press_q    <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= '0;
      end
      state_q    <= '0;
      dir_q      <= 1'b0;
      wrap_q     <= 4'd0;
      auto_cnt_q <= '0;
      ledr_q     <= BasePat;
      hex0_q     <= 8'hC0;
      hex1_q     <= 8'hC0;
    end else begin
      sync1_q    <= bus.KEY;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      press_q    <= press_d;
      for (int i = 0; i < 2; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      state_q    <= state_d;
      dir_q      <= dir_d;
      wrap_q     <= wrap_d;
      auto_cnt_q <= auto_cnt_d;
      ledr_q     <= ledr_d;
      hex0_q     <= hex0_d;
      hex1_q     <= hex1_d;
    end
  end

  assign bus.LEDR = ledr_q;
  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Self-checking bench for pattern_sequencer: one manual-only instance and one
// auto-stepping instance, a vector table, hand-written corner sequences and a
// randomized press sequence checked against an arithmetic reference model.
module tb_pattern_sequencer;

  localparam int N  = 4;
  localparam int LW = 10;
  localparam int D  = 4;
  localparam int AP = 8;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  pattern_sequencer_if #(.LED_WIDTH(LW)) bm ();
  pattern_sequencer_if #(.LED_WIDTH(LW)) ba ();

  pattern_sequencer #(
    .NUM_STATES(N), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(D), .AUTO_PERIOD(0)
  ) u_man (
    .clk  (clk),
    .reset(reset),
    .bus  (bm)
  );

  pattern_sequencer #(
    .NUM_STATES(N), .LED_WIDTH(LW), .DEBOUNCE_CYCLES(D), .AUTO_PERIOD(AP)
  ) u_auto (
    .clk  (clk),
    .reset(reset),
    .bus  (ba)
  );

  int checks = 0;
  int errors = 0;

  // Reference model of the manual instance.
  int m_state, m_dir, m_wrap;

  logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  typedef struct {
    bit         k0;
    bit         k1;
    logic [9:0] ledr;
    logic [7:0] h0;
    logic [7:0] h1;
  } vec_t;

  vec_t vecs [7];

  function automatic logic [LW-1:0] model_ledr(input int s);
    int sh, base, full;
    sh   = s % LW;
    base = 0;
    for (int i = 0; i < LW; i++) begin
      if (i % 2 == 1) base += (1 << i);
    end
    full = (1 << LW) - 1;
    return LW'(((base << sh) | (base >> (LW - sh))) & full);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_man(input string tag);
    check({tag, " LEDR"}, 32'(bm.LEDR), 32'(model_ledr(m_state)));
    check({tag, " HEX0"}, 32'(bm.HEX0), 32'(seg_tbl[m_state]));
    check({tag, " HEX1"}, 32'(bm.HEX1), 32'(seg_tbl[m_wrap]));
  endtask

  task automatic model_reset();
    m_state = 0;
    m_dir   = 0;
    m_wrap  = 0;
  endtask

  task automatic model_step(input bit k0, input bit k1);
    if (k1) m_dir = 1 - m_dir;
    if (k0) begin
      if (m_dir == 0) begin
        m_wrap  = (m_wrap + (m_state + 1) / N) % 16;
        m_state = (m_state + 1) % N;
      end else begin
        m_state = (m_state + N - 1) % N;
        if (m_state == N - 1) m_wrap = (m_wrap + 15) % 16;
      end
    end
  endtask

  // Returns #1 after the last reset edge; the next posedge is edge 1 after release.
  task automatic do_reset(input int cycles);
    @(posedge clk); #1;
    reset  = 1'b0;
    bm.KEY = 2'b11;
    ba.KEY = 2'b11;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
  endtask

  // Clean press of the selected keys on the manual instance: the update must land
  // exactly D+3 edges after the first low sample, then hold and release cleanly.
  task automatic key_event(input bit k0, input bit k1, input int extra);
    @(posedge clk); #1;
    bm.KEY = {~k1, ~k0};
    repeat (D + 3) @(posedge clk);
    #1;
    check_man("pre-update");
    @(posedge clk); #1;
    model_step(k0, k1);
    check_man("update");
    repeat (extra) @(posedge clk);
    #1;
    check_man("held");
    bm.KEY = 2'b11;
    repeat (D + 4) @(posedge clk);
    #1;
    check_man("released");
  endtask

  initial begin
    bm.KEY = 2'b11;
    ba.KEY = 2'b11;
    model_reset();

    vecs[0] = '{k0: 1'b1, k1: 1'b0, ledr: 10'h155, h0: 8'hF9, h1: 8'hC0};
    vecs[1] = '{k0: 1'b1, k1: 1'b0, ledr: 10'h2AA, h0: 8'hA4, h1: 8'hC0};
    vecs[2] = '{k0: 1'b1, k1: 1'b0, ledr: 10'h155, h0: 8'hB0, h1: 8'hC0};
    vecs[3] = '{k0: 1'b1, k1: 1'b0, ledr: 10'h2AA, h0: 8'hC0, h1: 8'hF9};
    vecs[4] = '{k0: 1'b0, k1: 1'b1, ledr: 10'h2AA, h0: 8'hC0, h1: 8'hF9};
    vecs[5] = '{k0: 1'b1, k1: 1'b0, ledr: 10'h155, h0: 8'hB0, h1: 8'hC0};
    vecs[6] = '{k0: 1'b1, k1: 1'b1, ledr: 10'h2AA, h0: 8'hC0, h1: 8'hF9};

    // Reset values on both instances.
    do_reset(3);
    check("reset LEDR", 32'(bm.LEDR), 32'h2AA);
    check("reset HEX0", 32'(bm.HEX0), 32'hC0);
    check("reset HEX1", 32'(bm.HEX1), 32'hC0);
    check("auto reset LEDR", 32'(ba.LEDR), 32'h2AA);
    check("auto reset HEX0", 32'(ba.HEX0), 32'hC0);

    // Forward wrap, direction toggle, simultaneous toggle+step.
    for (int i = 0; i < 7; i++) begin
      key_event(vecs[i].k0, vecs[i].k1, 1);
      check($sformatf("vec%0d LEDR", i), 32'(bm.LEDR), 32'(vecs[i].ledr));
      check($sformatf("vec%0d HEX0", i), 32'(bm.HEX0), 32'(vecs[i].h0));
      check($sformatf("vec%0d HEX1", i), 32'(bm.HEX1), 32'(vecs[i].h1));
    end

    // Backward step from state 0 after reset.
    do_reset(2);
    key_event(1'b0, 1'b1, 0);
    key_event(1'b1, 1'b0, 0);
    check("reverse HEX0", 32'(bm.HEX0), 32'hB0);
    check("reverse HEX1", 32'(bm.HEX1), 32'h8E);

    // Bounce rejection, then one long press gives exactly one step.
    do_reset(2);
    for (int r = 0; r < 5; r++) begin
      bm.KEY[0] = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      bm.KEY[0] = 1'b1;
      @(posedge clk); #1;
    end
    repeat (D + 6) @(posedge clk);
    #1;
    check_man("bounce");
    key_event(1'b1, 1'b0, 20 - (D + 3));
    check("long press HEX0", 32'(bm.HEX0), 32'hF9);

    // Randomized clean presses against the model.
    for (int i = 0; i < 12; i++) begin
      int sel;
      sel = $urandom_range(0, 2);
      key_event(sel != 1, sel != 0, $urandom_range(0, 6));
    end

    // Mid-operation reset: state 2, debounce counter at 2, then reset.
    do_reset(2);
    key_event(1'b1, 1'b0, 0);
    key_event(1'b1, 1'b0, 0);
    check("pre-reset HEX0", 32'(bm.HEX0), 32'hA4);
    @(posedge clk); #1;
    bm.KEY[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset  = 1'b0;
    bm.KEY = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_man("mid reset");
    reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check_man("after mid reset");

    // Auto stepping and tick/press collision.
    do_reset(3);
    repeat (7) @(posedge clk);
    #1;
    check("auto e7 HEX0", 32'(ba.HEX0), 32'hC0);
    @(posedge clk); #1;
    check("auto e8 HEX0", 32'(ba.HEX0), 32'hF9);
    check("auto e8 LEDR", 32'(ba.LEDR), 32'h155);
    repeat (7) @(posedge clk);
    #1;
    check("auto e15 HEX0", 32'(ba.HEX0), 32'hF9);
    @(posedge clk); #1;
    check("auto e16 HEX0", 32'(ba.HEX0), 32'hA4);
    repeat (8) @(posedge clk);
    #1;
    check("auto e24 HEX0", 32'(ba.HEX0), 32'hB0);
    // First low sample at edge 25, so the press steps on edge 32 with the tick.
    ba.KEY[0] = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("auto e31 HEX0", 32'(ba.HEX0), 32'hB0);
    @(posedge clk); #1;
    check("collision HEX0", 32'(ba.HEX0), 32'hC0);
    check("collision HEX1", 32'(ba.HEX1), 32'hF9);
    ba.KEY[0] = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("auto e39 HEX0", 32'(ba.HEX0), 32'hC0);
    @(posedge clk); #1;
    check("auto e40 HEX0", 32'(ba.HEX0), 32'hF9);
    repeat (8) @(posedge clk);
    #1;
    check("auto e48 HEX0", 32'(ba.HEX0), 32'hA4);
    check("auto e48 HEX1", 32'(ba.HEX1), 32'hF9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
